// File: rtl/pwm_seq.sv
// Duty-table sequencer feeding a pwm stream input. One entry per pwm period, repeated ctl_rep+1 times; one-shot or loop.
// Latency: str_dat updates the cycle after str_rdy (stop clears it the next cycle). Backpressure: only advances on str_rdy.
// Optional build macro PWM_SEQ_CLAMP_EN clamps played values to CCE.
module pwm_seq #(
  parameter int CCW = 4,
  parameter int CCE = 2**CCW-1,
  parameter int AW  = 4,
  parameter int RW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_adr,
  input  logic [CCW-1:0] cfg_dat,
  input  logic           ctl_start,
  input  logic           ctl_stop,
  input  logic [AW-1:0]  ctl_len,
  input  logic [RW-1:0]  ctl_rep,
  input  logic           ctl_loop,
  output logic           sts_busy,
  output logic           sts_done,
  output logic [AW-1:0]  sts_ptr,
  output logic [CCW-1:0] str_dat,
  input  logic           str_rdy
);

  typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

`ifdef PWM_SEQ_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif
  localparam logic [CCW-1:0] CCE_V = CCW'(CCE);

  state_t         state, state_nxt;
  logic [CCW-1:0] tbl [2**AW];
  logic [AW-1:0]  ptr, ptr_nxt, len_q, len_nxt;
  logic [RW-1:0]  rep_cnt, rep_cnt_nxt, rep_q, rep_nxt;
  logic           loop_q, loop_nxt;
  logic [CCW-1:0] rd_dat, ld_dat, dat_nxt;
  logic           done_nxt;

  // Table RAM: not reset; same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (cfg_we) tbl[cfg_adr] <= cfg_dat;
  end

  assign rd_dat = tbl[ptr];
  assign ld_dat = (CLAMP && (rd_dat > CCE_V)) ? CCE_V : rd_dat;

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    rep_cnt_nxt = rep_cnt;
    len_nxt     = len_q;
    rep_nxt     = rep_q;
    loop_nxt    = loop_q;
    dat_nxt     = str_dat;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        dat_nxt = '0;
        if (ctl_start && !ctl_stop) begin
          state_nxt   = RUN;
          ptr_nxt     = '0;
          rep_cnt_nxt = '0;
          len_nxt     = ctl_len;
          rep_nxt     = ctl_rep;
          loop_nxt    = ctl_loop;
        end
      end
      RUN: begin
        if (ctl_stop) begin
          state_nxt = IDLE;
          dat_nxt   = '0;
          done_nxt  = 1'b1;
        end else if (str_rdy) begin
          dat_nxt = ld_dat;
          if (rep_cnt < rep_q) begin
            rep_cnt_nxt = rep_cnt + RW'(1);
          end else begin
            rep_cnt_nxt = '0;
            if (ptr < len_q)  ptr_nxt   = ptr + AW'(1);
            else if (loop_q)  ptr_nxt   = '0;
            else              state_nxt = LAST;
          end
        end
      end
      LAST: begin
        // Final entry is playing; retire it at the next period boundary.
        if (ctl_stop || str_rdy) begin
          state_nxt = IDLE;
          dat_nxt   = '0;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        dat_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      rep_cnt  <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      loop_q   <= 1'b0;
      str_dat  <= '0;
      sts_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      rep_cnt  <= rep_cnt_nxt;
      len_q    <= len_nxt;
      rep_q    <= rep_nxt;
      loop_q   <= loop_nxt;
      str_dat  <= dat_nxt;
      sts_done <= done_nxt;
    end
  end

  assign sts_busy = (state != IDLE);
  assign sts_ptr  = ptr;

endmodule
